// File: rtl/branch_flag_gen.sv
// rtl/branch_flag_gen.sv - branch condition flag producer with a two-entry output buffer
//
// Computes a - b, forms the z/s/v/c flags at accept time and queues
// {z, s, v, c, funct3, target} in a two-entry in-order buffer toward the
// branch-resolution stage.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        input handshake (in_ready depends on state only)
//   a, b                       operands (rs1, rs2)
//   in_funct3, in_target       passed through with the flags
//   flush                      synchronous drop of every buffered entry
//   out_valid / out_ready      output handshake for the head entry
//   z, s, v, c                 flags of the head entry
//   out_funct3, out_target     funct3 and target of the head entry

module branch_flag_gen #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       in_funct3,
    input  logic [WIDTH-1:0] in_target,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             z,
    output logic             s,
    output logic             v,
    output logic             c,
    output logic [2:0]       out_funct3,
    output logic [WIDTH-1:0] out_target
);

    localparam int EW = WIDTH + 7;

    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] r;
    logic             fz, fs, fv, fc;
    logic [EW-1:0]    new_entry;

    logic [EW-1:0]    mem [2];
    logic             rd_ptr, wr_ptr;
    logic [1:0]       count;
    logic [EW-1:0]    head_q;

    logic             push, pop;
    logic             rd_n, wr_n;
    logic [1:0]       count_n;
    logic [EW-1:0]    head_n;

    // a + ~b + 1 keeps the carry-out as the "no borrow" flag.
    assign diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    assign r    = diff[WIDTH-1:0];
    assign fz   = (r == '0);
    assign fs   = r[WIDTH-1];
    assign fc   = diff[WIDTH];
    assign fv   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);

    assign new_entry = {fz, fs, fv, fc, in_funct3, in_target};

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        rd_n    = rd_ptr ^ pop;
        wr_n    = wr_ptr ^ push;
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + 2'd1;
            2'b01:   count_n = count - 2'd1;
            default: count_n = count;
        endcase
        if (flush) begin
            rd_n    = 1'b0;
            wr_n    = 1'b0;
            count_n = 2'd0;
        end
    end

    // The visible head is a register so the outputs are glitch-free and keep
    // their last value once the buffer drains. When the incoming entry lands
    // in the slot that becomes the head, it has not been written to mem yet,
    // so it is taken straight from new_entry.
    always_comb begin
        head_n = head_q;
        if (!flush && count_n != 2'd0) begin
            if (push && (count == 2'd0 || (pop && count == 2'd1))) begin
                head_n = new_entry;
            end else begin
                head_n = mem[rd_n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            head_q <= '0;
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count  <= count_n;
            rd_ptr <= rd_n;
            wr_ptr <= wr_n;
            head_q <= head_n;
            if (push) begin
                mem[wr_ptr] <= new_entry;
            end
        end
    end

    assign z          = head_q[EW-1];
    assign s          = head_q[EW-2];
    assign v          = head_q[EW-3];
    assign c          = head_q[EW-4];
    assign out_funct3 = head_q[WIDTH+2:WIDTH];
    assign out_target = head_q[WIDTH-1:0];

endmodule

// File: doc/branch_flag_gen.md
# branch_flag_gen

Execute-stage producer of the branch condition flags (z, s, v, c) that the Comparator consumes together with funct3. Subtracts operand b from operand a, forms the four flags, and presents them with the instruction's funct3 and branch target through a registered, two-entry, valid/ready-buffered output. The buffer decouples the ALU side from a stalling branch-resolution stage.

## Interface
- WIDTH, 32, operand and target width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a, b, in_funct3, in_target carry a branch to evaluate
- in_ready  output  1  block accepts input this cycle
- a  input  WIDTH  rs1 operand
- b  input  WIDTH  rs2 operand
- in_funct3  input  3  branch funct3, passed through unchanged
- in_target  input  WIDTH  branch target address, passed through unchanged
- flush  input  1  synchronous pipeline flush, drops all buffered entries
- out_valid  output  1  head entry is valid
- out_ready  input  1  consumer takes head entry this cycle
- z, s, v, c  output  1 each  flags of head entry
- out_funct3  output  3  funct3 of head entry
- out_target  output  WIDTH  target of head entry

## Operation
- Arithmetic: diff = {1'b0,a} + {1'b0,~b} + 1, WIDTH+1 bits; r = diff[WIDTH-1:0].
- z = (r == 0); s = r[WIDTH-1]; c = diff[WIDTH] (1 = no borrow, a ≥ b unsigned); v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]).
- Flags are computed at accept time and stored; stored entries never recompute.
- Storage: 2-entry in-order FIFO of {z,s,v,c,funct3,target}, count 0..2, read/write pointers 1 bit each, wrap 1→0.
- Push = in_valid && in_ready && !flush. Pop = out_valid && out_ready && !flush.
- in_ready = (count < 2). Combinational from state only; never depends on in_valid or out_ready.
- out_valid = (count > 0). Outputs z..out_target show the head entry; they hold their last value when count = 0.
- Count update: push only +1; pop only −1; push and pop together → unchanged (legal at count 1; at count 2 no push because in_ready = 0; at count 0 no pop).
- Flush: count ← 0, both pointers ← 0, concurrent input discarded, concurrent pop not counted as a transfer. in_ready is 1 the next cycle.
- Ordering: entries leave strictly in acceptance order.

## Timing
- Reset (rst_n low, asynchronous): count = 0, pointers = 0, out_valid = 0, in_ready = 1, z = s = v = c = 0, out_funct3 = 0, out_target = 0, storage cleared. Reset mid-transfer discards all entries with no partial output.
- Latency: input accepted at edge N → out_valid = 1 and flags valid after edge N (visible in cycle N+1). No combinational path from inputs to outputs.
- Throughput: one entry per cycle with out_ready held high.
- Backpressure: out_ready = 0 with two entries held → in_ready = 0 the following cycle. The first pop re-asserts in_ready one cycle later (registered count).
- Handshake rule: while out_valid = 1 and out_ready = 0, the head outputs are stable.

## Test plan
- Equal operands: a = 5, b = 5, in_funct3 = 000, out_ready = 1 → one cycle later out_valid = 1, z = 1, s = 0, v = 0, c = 1, out_funct3 = 000.
- Signed overflow: a = 0x8000_0000, b = 1 → r = 0x7FFF_FFFF, z = 0, s = 0, v = 1, c = 1. Borrow: a = 1, b = 2 → r = 0xFFFF_FFFF, s = 1, v = 0, c = 0.
- Backpressure: out_ready = 0; push targets 0x100, 0x104 → in_ready = 0, third input held. Raise out_ready → 0x100, then 0x104, then the third input, in order, with no duplicates.
- Streaming: out_ready = 1, ten back-to-back inputs → ten outputs on consecutive cycles, count never exceeds 1.
- Flush: two entries buffered, flush = 1 with in_valid = 1 → next cycle out_valid = 0, in_ready = 1, flushed input never appears.
- Async reset: assert rst_n low mid-stream between clock edges → outputs go to reset values immediately. Release → first new input appears with 1-cycle latency.
